// File: rtl/ro_freq_pkg.sv
// ro_freq_pkg: register map, bit indices and FSM states of the ring-oscillator frequency counter.
package ro_freq_pkg;
  localparam logic [3:0] OFF_CTRL = 4'h0, OFF_GATE = 4'h4, OFF_COUNT = 4'h8, OFF_STATUS = 4'hC;
  localparam int CTRL_START = 0, CTRL_ABORT = 1, CTRL_CONT = 2, CTRL_SEL = 4;
  localparam int ST_BUSY = 0, ST_DONE = 1, ST_OVF = 2;
  typedef enum logic [1:0] {IDLE, SETTLE, MEAS, DONE} state_t;
endpackage

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: SYNC_STAGES-deep synchronizer for an asynchronous input plus a rising-edge pulse.
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic [SYNC_STAGES:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= {sr[SYNC_STAGES-1:0], din};
  assign rise = sr[SYNC_STAGES-1] & ~sr[SYNC_STAGES];
endmodule

// File: rtl/ro_freq_counter.sv
// ro_freq_counter: Wishbone-controlled gated edge counter for the muxed ring oscillator.
// FREQCNT_CONTINUOUS_EN adds CTRL.cont: back-to-back windows with a shadow accumulator.
module ro_freq_counter
  import ro_freq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int          CNT_W         = 32,
  parameter int          SETTLE_CYCLES = 8,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        ro_i,
  output logic [3:0]  ro_sel_o,
  output logic        irq_o
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  state_t state, nxt;
  logic req, wr, wr_ctrl, wr_status, start, abort, clr, go;
  logic busy, meas, set_done, rise, done, ovf, sat, cont;
  logic [3:0] off, sel;
  logic [31:0] gate, gate_lat, gate_cnt, rdata;
  logic [SW-1:0] settle_cnt;
  logic [CNT_W-1:0] count, acc;
  logic unused_sel;
  assign unused_sel = ^wbs_sel_i;
  assign off = wbs_adr_i[3:0];
  // Excluding the ack cycle keeps a held request from being acked twice in a row.
  assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
  assign wr = req & wbs_we_i;
  assign wr_ctrl = wr & (off == OFF_CTRL);
  assign wr_status = wr & (off == OFF_STATUS);
  assign start = wr_ctrl & wbs_dat_i[CTRL_START];
  assign abort = wr_ctrl & wbs_dat_i[CTRL_ABORT];
  assign clr = (state == IDLE) & start & ~abort;
  assign go = (nxt == SETTLE) & (state != SETTLE);
  assign sat = meas & rise & (&acc);
  assign ro_sel_o = sel;
  assign irq_o = done;
  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .din(ro_i), .rise(rise)
  );
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   nxt = clr ? SETTLE : IDLE;
      SETTLE: nxt = abort ? IDLE : settle_cnt != '0 ? SETTLE : gate_lat == '0 ? DONE : MEAS;
      MEAS:   nxt = abort ? IDLE : gate_cnt == 32'd1 ? DONE : MEAS;
      DONE:   nxt = (cont & ~abort) ? SETTLE : IDLE;
    endcase
  end
  always_comb begin
    busy = (state == SETTLE) | (state == MEAS);
    meas = state == MEAS;
    set_done = state == DONE;
  end
  always_comb
    rdata = off == OFF_CTRL   ? 32'({sel, 1'b0, cont, 2'b00}) :
            off == OFF_GATE   ? gate :
            off == OFF_COUNT  ? 32'(count) :
            off == OFF_STATUS ? {29'd0, ovf, done, busy} : 32'd0;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      sel <= '0;
      gate <= '0;
      gate_lat <= '0;
      gate_cnt <= '0;
      settle_cnt <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rdata : 32'd0;
      if (wr_ctrl && !busy) sel <= wbs_dat_i[CTRL_SEL +: 4];
      if (wr && off == OFF_GATE) gate <= wbs_dat_i;
      if (clr) gate_lat <= gate;
      settle_cnt <= go ? SW'(SETTLE_CYCLES - 1) : settle_cnt - SW'(state == SETTLE);
      gate_cnt <= state == SETTLE ? gate_lat : gate_cnt - 32'(meas);
      done <= clr ? 1'b0 : set_done | (done & ~(wr_status & wbs_dat_i[ST_DONE]));
      ovf <= clr ? 1'b0 : sat | (ovf & ~(wr_status & wbs_dat_i[ST_OVF]));
    end
`ifdef FREQCNT_CONTINUOUS_EN
  // COUNT publishes the last finished window while acc fills the next one.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      cont <= 1'b0;
      acc <= '0;
      count <= '0;
    end else begin
      if (wr_ctrl) cont <= wbs_dat_i[CTRL_CONT];
      if (go) acc <= '0;
      else if (meas && rise && !(&acc)) acc <= acc + CNT_W'(1);
      if (clr) count <= '0;
      else if (set_done) count <= acc;
    end
`else
  assign cont = 1'b0;
  assign acc = count;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) count <= '0;
    else if (clr) count <= '0;
    else if (meas && rise && !(&count)) count <= count + CNT_W'(1);
`endif
endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: directed self-checking bench for ro_freq_counter (CNT_W=8 to reach saturation).
module tb_ro_freq_counter;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0, ro = 0;
  logic [3:0] bsel = 4'hF;
  logic [31:0] adr = 0, wdat = 0, q;
  logic ack, irq;
  logic [31:0] rdat;
  logic [3:0] ro_sel;
  logic got;
  int checks = 0, errors = 0, half = 0, n, m;
  always #5 clk = ~clk;
  ro_freq_counter #(.BASE_ADDR(BASE), .CNT_W(8), .SETTLE_CYCLES(8), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(bsel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .ro_i(ro), .ro_sel_o(ro_sel), .irq_o(irq)
  );
  // Oscillator model: toggles every 'half' clocks, so its period is 2*half clocks.
  initial forever begin
    if (half == 0) begin
      ro = 0;
      @(negedge clk);
    end else begin
      repeat (half) @(negedge clk);
      ro = ~ro;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rq, output logic ok);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; ok = 0; rq = 0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1; rq = rdat; end
    end
    cyc = 0; stb = 0; we = 0;
  endtask
  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] x;
    logic ok;
    bus(1, BASE + off, d, x, ok);
    check("wr_ack", 32'(ok), 1);
  endtask
  task automatic rd(input logic [31:0] off, output logic [31:0] rq);
    logic ok;
    bus(0, BASE + off, 0, rq, ok);
    check("rd_ack", 32'(ok), 1);
  endtask
  task automatic wait_irq(input int budget, output int cnt);
    cnt = 0;
    while (!irq && cnt < budget) begin @(posedge clk); #1; cnt++; end
  endtask
  task automatic cycles(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask
  initial begin
    cycles(3);
    check("rst_ack", 32'(ack), 0);
    check("rst_dat", rdat, 0);
    check("rst_sel", 32'(ro_sel), 0);
    check("rst_irq", 32'(irq), 0);
    rst_n = 1;
    cycles(1);
    rd(12, q); check("rst_status", q, 0);
    rd(8, q);  check("rst_count", q, 0);
    rd(4, q);  check("rst_gate", q, 0);
    // single shot, oscillator at f/10, gate 1000
    half = 5;
    wr(0, 32'h50);
    check("sel_out", 32'(ro_sel), 5);
    rd(0, q); check("ctrl_rd", q, 32'h50);
    wr(4, 1000);
    rd(4, q); check("gate_rd", q, 1000);
    wr(0, 32'h51);
    wait_irq(1200, n);
    check("meas_latency", n, 1009);
    check("sel_hold", 32'(ro_sel), 5);
    rd(8, q);  check("count_f10", q, 100);
    rd(12, q); check("status_done", q, 2);
    wr(12, 2);
    check("irq_clr", 32'(irq), 0);
    // bus decode
    wr(5, 32'h55);
    rd(4, q); check("unmapped_wr_drop", q, 1000);
    rd(6, q); check("unmapped_rd", q, 0);
    bus(0, BASE + 32'h10, 0, q, got); check("out_of_range_noack", 32'(got), 0);
    bus(1, 32'h4000_0004, 7, q, got); check("foreign_noack", 32'(got), 0);
    rd(4, q); check("foreign_wr_drop", q, 1000);
    // zero gate
    wr(4, 0);
    wr(0, 32'h51);
    wait_irq(50, n);
    check("gate0_latency", n, 9);
    rd(8, q);  check("gate0_count", q, 0);
    rd(12, q); check("gate0_status", q, 2);
    wr(12, 2);
    check("gate0_irq_clr", 32'(irq), 0);
    rd(12, q); check("gate0_status_clr", q, 0);
    // start and abort together: abort wins
    wr(0, 32'h53);
    rd(12, q); check("start_abort", q, 0);
    // abort after ~300 MEAS cycles, with a sel write that must be ignored
    wr(4, 1000);
    wr(0, 32'h51);
    cycles(308);
    rd(12, q); check("busy_before_abort", q, 1);
    wr(0, 32'h92);
    check("sel_frozen", 32'(ro_sel), 5);
    rd(12, q); check("abort_status", q, 0);
    rd(8, q);  check("abort_partial", 32'(q >= 29 && q <= 31), 1);
    check("abort_irq", 32'(irq), 0);
    // saturation at 255, oscillator at f/4
    half = 2;
    wr(4, 2000);
    wr(0, 32'h51);
    wait_irq(2100, n);
    check("ovf_latency", n, 2009);
    rd(8, q);  check("ovf_count", q, 255);
    rd(12, q); check("ovf_status", q, 6);
    wr(12, 4);
    rd(12, q); check("ovf_clr", q, 2);
    wr(12, 2);
`ifdef FREQCNT_CONTINUOUS_EN
    half = 5;
    wr(4, 20);
    wr(0, 32'h55);
    wait_irq(100, n);
    check("cont_first", n, 29);
    wr(12, 2);
    wait_irq(100, m);
    check("cont_period", m, 28);
    rd(8, q); check("cont_count", q, 2);
    rd(0, q); check("cont_rd", q, 32'h54);
    wr(0, 32'h50);
    cycles(40);
    rd(12, q); check("cont_stop", q & 32'h1, 0);
    wr(12, 6);
`endif
    // reset during MEAS
    half = 5;
    wr(4, 1000);
    wr(0, 32'h71);
    cycles(100);
    check("sel_before_rst", 32'(ro_sel), 7);
    rst_n = 0;
    #1;
    check("midrst_sel", 32'(ro_sel), 0);
    check("midrst_irq", 32'(irq), 0);
    check("midrst_ack", 32'(ack), 0);
    check("midrst_dat", rdat, 0);
    @(posedge clk); #1;
    rst_n = 1;
    cycles(1);
    rd(8, q);  check("midrst_count", q, 0);
    rd(0, q);  check("midrst_ctrl", q, 0);
    rd(4, q);  check("midrst_gate", q, 0);
    rd(12, q); check("midrst_status", q, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
